if_fetch: RTL and testbench

Instruction-fetch stage that consumes the PC register's address stream and throttles it. It issues in-order requests to instruction memory over a valid/ready channel and buffers returned words with their PCs in a small queue toward decode. It drives the stall input of the PC register whenever a fetch cannot be issued. On a taken branch or jump it discards all wrong-path responses, in flight or queued.

---
 rtl/if_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 56 +++++
 rtl/if_fetch.sv | 118 +++++++++++
 tb/tb_if_fetch.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: default sizes, the
// decode-queue entry layout and the occupancy counter width helper.
package if_pkg;

  localparam int DEPTH_DEF = 4;
  localparam int XLEN_DEF  = 32;
  localparam int CNT_W     = $clog2(DEPTH_DEF + 1);

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] instr;
  } fetch_entry_t;

  // A counter that must reach `depth` itself, not just depth-1.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush, occupancy count and full/empty flags.
// DEPTH must be a power of two so the pointers wrap on their own.
module fetch_fifo
  import if_pkg::*;
#(
  parameter int  DEPTH = DEPTH_DEF,
  parameter type T     = logic [31:0]
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  T                             din,
  output T                             dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  T             mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: credit-limited in-order requests to imem, a registered
// decode queue, PC stall generation and wrong-path discard on redirect.
module if_fetch
  import if_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int XLEN  = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  input  logic            redirect,
  output logic            pc_stall,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            id_valid,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  input  logic            id_ready
);

  localparam int CW = cnt_width(DEPTH);

  logic [CW-1:0]   live;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   qcnt;
  logic [CW-1:0]   acnt;
  logic [CW+1:0]   occ;
  logic            credit;
  logic            req_fire;
  logic            rsp_live;
  logic            rsp_drop;
  logic            q_push;
  logic            q_pop;
  logic            addr_full, addr_empty, q_full, q_empty;
  logic [XLEN-1:0] addr_head;
  fetch_entry_t    q_din;
  fetch_entry_t    q_dout;

  assign occ    = (CW+2)'(live) + (CW+2)'(drop) + (CW+2)'(qcnt);
  assign credit = occ < (CW+2)'(DEPTH);

  assign imem_req_valid = !rst && !redirect && credit;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  // PC advances only on an accepted fetch, but must load the target on redirect.
  assign pc_stall       = rst || (!redirect && !req_fire);

  assign rsp_drop = imem_rsp_valid && (drop != '0);
  assign rsp_live = imem_rsp_valid && (drop == '0) && !addr_empty;
  assign q_push   = rsp_live && !redirect;

  assign id_valid = !q_empty && !redirect;
  assign q_pop    = id_valid && id_ready;
  assign id_pc    = q_dout.pc;
  assign id_instr = q_dout.instr;

  assign q_din.pc    = addr_head;
  assign q_din.instr = imem_rsp_data;

  fetch_fifo #(.DEPTH(DEPTH), .T(logic [XLEN-1:0])) u_addr_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (req_fire),
    .pop   (rsp_live),
    .din   (pc),
    .dout  (addr_head),
    .count (acnt),
    .full  (addr_full),
    .empty (addr_empty)
  );

  fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (q_push),
    .pop   (q_pop),
    .din   (q_din),
    .dout  (q_dout),
    .count (qcnt),
    .full  (q_full),
    .empty (q_empty)
  );

  // On redirect everything still in flight becomes a drop, minus the one
  // response (live or dropped) retired in this very cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      live <= '0;
      drop <= '0;
    end else if (redirect) begin
      live <= '0;
      drop <= drop + live - CW'(rsp_live) - CW'(rsp_drop);
    end else begin
      live <= live + CW'(req_fire) - CW'(rsp_live);
      drop <= drop - CW'(rsp_drop);
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(imem_rsp_valid && live == '0 && drop == '0))
        else $error("if_fetch: imem response with nothing outstanding");
      assert (acnt == live)
        else $error("if_fetch: address fifo out of step with live count");
      assert (!(req_fire && addr_full) && !(q_push && q_full))
        else $error("if_fetch: push into a full fifo");
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a PC-register model, a fixed-latency
// memory model and a scoreboard of expected decode entries.
module tb_if_fetch;
  import if_pkg::*;

  logic        clk = 1'b0;
  logic        rst, redirect, pc_stall, imem_req_valid, imem_req_ready;
  logic        imem_rsp_valid, id_valid, id_ready;
  logic [31:0] pc, imem_req_addr, imem_rsp_data, id_instr, id_pc;

  always #5 clk = ~clk;

  if_fetch #(.DEPTH(4), .XLEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .redirect       (redirect),
    .pc_stall       (pc_stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_ready       (id_ready)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  int           passes = 0;
  int           total  = 0;
  int           cyc    = 0;
  int           lat    = 1;
  logic [31:0]  target = '0;
  mreq_t        mem_q[$];
  fetch_entry_t exp_q[$];
  logic [31:0]  pop_log[$];

  logic        s_fire, s_stall, s_req_valid, s_id_valid;
  logic [31:0] s_addr, s_id_pc, s_id_instr;
  logic [2:0]  s_live, s_drop, s_qcnt;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h5A5A_F00D;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock: sample at negedge, score, then advance PC and memory models.
  task automatic tick();
    mreq_t        m;
    fetch_entry_t e;
    @(negedge clk);
    s_fire      = imem_req_valid && imem_req_ready;
    s_stall     = pc_stall;
    s_req_valid = imem_req_valid;
    s_addr      = imem_req_addr;
    s_id_valid  = id_valid;
    s_id_pc     = id_pc;
    s_id_instr  = id_instr;
    s_live      = dut.live;
    s_drop      = dut.drop;
    s_qcnt      = dut.qcnt;
    if (imem_req_valid === 1'b1) chk("req_addr", imem_req_addr, pc);
    if (redirect) chk("no_req_on_redirect", imem_req_valid, 1'b0);
    if (id_valid === 1'b1 && id_ready) begin
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_pc", id_pc, e.pc);
        chk("sb_instr", id_instr, e.instr);
      end
      pop_log.push_back(id_pc);
    end
    if (rst || redirect) exp_q.delete();
    if (s_fire === 1'b1) exp_q.push_back('{pc: pc, instr: mem_data(pc)});
    @(posedge clk);
    #1;
    cyc++;
    if (rst) mem_q.delete();
    else if (s_fire === 1'b1) mem_q.push_back('{addr: pc, due: cyc - 1 + lat});
    if (rst) pc = '0;
    else if (redirect) pc = target;
    else if (s_stall === 1'b0) pc = pc + 32'd4;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      m = mem_q.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_data(m.addr);
    end
  endtask

  task automatic do_reset(input int l, input logic rdy);
    rst            = 1'b1;
    redirect       = 1'b0;
    imem_req_ready = 1'b1;
    lat            = l;
    id_ready       = rdy;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int nf;
    int k;
    pc = '0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;

    // reset values
    do_reset(1, 1'b1);
    chk("rst_req_valid", s_req_valid, 1'b0);
    chk("rst_id_valid", s_id_valid, 1'b0);
    chk("rst_stall", s_stall, 1'b1);
    chk("rst_live", s_live, 3'd0);
    chk("rst_drop", s_drop, 3'd0);
    chk("rst_qcnt", s_qcnt, 3'd0);

    // reset release, 1-cycle memory
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t1_fire", s_fire, 1'b1);
      chk("t1_addr", s_addr, 32'(i * 4));
      chk("t1_stall", s_stall, 1'b0);
      chk("t1_id_valid", s_id_valid, 32'(i >= 2));
      if (i >= 2) begin
        chk("t1_id_pc", s_id_pc, 32'((i - 2) * 4));
        chk("t1_id_instr", s_id_instr, mem_data(32'((i - 2) * 4)));
      end
    end

    // decode backpressure
    do_reset(1, 1'b0);
    nf = 0;
    repeat (10) begin
      tick();
      if (s_fire) nf++;
    end
    chk("t2_nfire", 32'(nf), 32'd4);
    chk("t2_stall", s_stall, 1'b1);
    chk("t2_req_valid", s_req_valid, 1'b0);
    chk("t2_qcnt", s_qcnt, 3'd4);
    id_ready = 1'b1;
    pop_log.delete();
    for (k = 0; k < 30 && pop_log.size() < 4; k++) tick();
    chk("t2_drain_n", 32'(pop_log.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < pop_log.size(); i++) chk("t2_drain_pc", pop_log[i], 32'(i * 4));

    // memory backpressure
    do_reset(1, 1'b1);
    repeat (4) tick();
    imem_req_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("t3_hold_addr", s_addr, 32'h10);
      chk("t3_hold_stall", s_stall, 1'b1);
      chk("t3_hold_valid", s_req_valid, 1'b1);
    end
    imem_req_ready = 1'b1;
    tick();
    chk("t3_resume_fire", s_fire, 1'b1);
    chk("t3_resume_addr", s_addr, 32'h10);
    tick();
    chk("t3_next_addr", s_addr, 32'h14);

    // redirect with 3 in flight and 1 queued, 3-cycle memory
    do_reset(3, 1'b0);
    repeat (4) tick();
    redirect = 1'b1; target = 32'h100; id_ready = 1'b1;
    tick();
    chk("t4_live_before", s_live, 3'd3);
    chk("t4_qcnt_before", s_qcnt, 3'd1);
    chk("t4_redir_valid", s_id_valid, 1'b0);
    chk("t4_redir_stall", s_stall, 1'b0);
    redirect = 1'b0;
    pop_log.delete();
    tick();
    chk("t4_drop", s_drop, 3'd2);
    chk("t4_qcnt_after", s_qcnt, 3'd0);
    chk("t4_target_addr", s_addr, 32'h100);
    for (k = 0; k < 20 && pop_log.size() == 0; k++) tick();
    chk("t4_first_lat", 32'(k), 32'd4);
    chk("t4_first_pc", pop_log.size() != 0 ? pop_log[0] : 32'hFFFF_FFFF, 32'h100);

    // redirect coincident with the only live response
    do_reset(1, 1'b1);
    tick();
    redirect = 1'b1; target = 32'h200;
    tick();
    chk("t5_live_before", s_live, 3'd1);
    redirect = 1'b0;
    pop_log.delete();
    tick();
    chk("t5_drop", s_drop, 3'd0);
    chk("t5_live", s_live, 3'd0);
    chk("t5_id_valid", s_id_valid, 1'b0);
    chk("t5_target_addr", s_addr, 32'h200);
    for (k = 0; k < 10 && pop_log.size() == 0; k++) tick();
    chk("t5_first_pc", pop_log.size() != 0 ? pop_log[0] : 32'hFFFF_FFFF, 32'h200);

    // reset mid-stream with 2 entries queued
    do_reset(1, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("t6_qcnt_before", s_qcnt, 3'd2);
    rst = 1'b0;
    tick();
    chk("t6_id_valid", s_id_valid, 1'b0);
    chk("t6_live", s_live, 3'd0);
    chk("t6_drop", s_drop, 3'd0);
    chk("t6_qcnt", s_qcnt, 3'd0);
    chk("t6_restart_addr", s_addr, 32'h0);
    tick();
    chk("t6_next_addr", s_addr, 32'h4);
    id_ready = 1'b1;
    repeat (6) tick();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", passes, total);
    $fatal(1, "watchdog");
  end

endmodule
